// File: rtl/counter_scan_pkg.sv
// Shared types and helpers for the counter RAM scan reader.
// Holds the scan FSM state encoding and the last-address helper.
// No logic; imported by counter_scan_reader.
package counter_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    CLEAR,
    FIN
  } scan_state_t;

  // Highest counter address for a RAM with the given address width.
  function automatic int unsigned SCAN_LAST(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_scan_reader.sv
// Purpose: walks every counter RAM address, streams (address, count) beats,
//          optionally clearing each entry after delivery and skipping zeros.
// Latency: READ/CAPT/SEND per entry (+CLEAR in clear mode); beat valid 2 cycles after start.
// Backpressure: beat held stable in SEND until out_ready; scan stalls meanwhile.
// Ports: clk/gen_reset_n; start/abort/clear_after_read/skip_zero control; busy/done status;
//        ram_adress/ram_count_read/ram_count_reset/ram_count_out to the counter RAM;
//        out_valid/out_ready/out_adress/out_data/out_last beat stream.
module counter_scan_reader
  import counter_scan_pkg::*;
#(
  parameter int bitsDirect  = 6,
  parameter int sizeCounter = 4
) (
  input  logic                   clk,
  input  logic                   gen_reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear_after_read,
  input  logic                   skip_zero,
  output logic                   busy,
  output logic                   done,
  output logic [bitsDirect-1:0]  ram_adress,
  output logic                   ram_count_read,
  output logic                   ram_count_reset,
  input  logic [sizeCounter-1:0] ram_count_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bitsDirect-1:0]  out_adress,
  output logic [sizeCounter-1:0] out_data,
  output logic                   out_last
);

  localparam logic [bitsDirect-1:0] LAST_ADDR = bitsDirect'(SCAN_LAST(bitsDirect));

  scan_state_t state_q, state_d;
  logic [bitsDirect-1:0]  addr_q, addr_d;
  logic [bitsDirect-1:0]  oadr_q, oadr_d;
  logic [sizeCounter-1:0] odat_q, odat_d;
  logic                   clr_q, clr_d;
  logic                   skip_q, skip_d;
  logic                   adv;

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oadr_q  <= '0;
      odat_q  <= '0;
      clr_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      oadr_q  <= oadr_d;
      odat_q  <= odat_d;
      clr_q   <= clr_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    oadr_d  = oadr_q;
    odat_d  = odat_q;
    clr_d   = clr_q;
    skip_d  = skip_q;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          addr_d  = '0;
          clr_d   = clear_after_read;
          skip_d  = skip_zero;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // A skipped zero is already clear, so it bypasses SEND and CLEAR.
        if (skip_q && (ram_count_out == '0)) begin
          adv = 1'b1;
        end else begin
          state_d = SEND;
          oadr_d  = addr_q;
          odat_d  = ram_count_out;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (clr_q) state_d = CLEAR;
          else       adv     = 1'b1;
        end
      end
      CLEAR:   adv     = 1'b1;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stop at the top address instead of wrapping back to 0.
    if (adv) begin
      if (addr_q == LAST_ADDR) begin
        state_d = FIN;
      end else begin
        state_d = READ;
        addr_d  = addr_q + 1'b1;
      end
    end

    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  assign busy            = (state_q == READ) || (state_q == CAPT) ||
                           (state_q == SEND) || (state_q == CLEAR);
  assign done            = (state_q == FIN);
  assign ram_adress      = addr_q;
  assign ram_count_read  = (state_q == READ);
  assign ram_count_reset = (state_q == CLEAR);
  assign out_valid       = (state_q == SEND);
  assign out_adress      = oadr_q;
  assign out_data        = odat_q;
  assign out_last        = out_valid && (oadr_q == LAST_ADDR);

endmodule

// File: tb/tb_counter_scan_reader.sv
// Bench for counter_scan_reader paired with a behavioural counter RAM.
// Directed scans with hand-computed beats, cycle counts and RAM contents.
// Consumer readiness driven on the falling edge; outputs sampled there too.
module tb_counter_scan_reader;

  logic       clk = 1'b0;
  logic       gen_reset_n;
  logic       start, abort, clear_after_read, skip_zero;
  logic       busy, done;
  logic [5:0] ram_adress;
  logic       ram_count_read, ram_count_reset;
  logic [3:0] ram_count_out;
  logic       out_valid, out_ready;
  logic [5:0] out_adress;
  logic [3:0] out_data;
  logic       out_last;

  // Counter RAM model: registered read, per-entry clear, increment port for preload.
  logic [3:0] mem [64];
  logic       inc, wipe;
  logic [5:0] tb_adr;
  logic [5:0] ram_a;
  assign ram_a = (ram_count_read || ram_count_reset) ? ram_adress : tb_adr;

  always @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      ram_count_out <= '0;
    end else begin
      if (ram_count_read) ram_count_out <= mem[ram_a];
      if (wipe) begin
        for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else if (ram_count_reset) begin
        mem[ram_a] <= '0;
      end else if (inc) begin
        mem[ram_a] <= mem[ram_a] + 4'd1;
      end
    end
  end

  counter_scan_reader #(.bitsDirect(6), .sizeCounter(4)) dut (
    .clk              (clk),
    .gen_reset_n      (gen_reset_n),
    .start            (start),
    .abort            (abort),
    .clear_after_read (clear_after_read),
    .skip_zero        (skip_zero),
    .busy             (busy),
    .done             (done),
    .ram_adress       (ram_adress),
    .ram_count_read   (ram_count_read),
    .ram_count_reset  (ram_count_reset),
    .ram_count_out    (ram_count_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_adress       (out_adress),
    .out_data         (out_data),
    .out_last         (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Beats collected by the last scan.
  int beat_adr[$];
  int beat_dat[$];
  int beat_last[$];
  bit got_done;
  int done_edge;

  task automatic check_idle_outs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_vld"},  out_valid, 0);
    check_val({tag, "_rd"},   ram_count_read, 0);
    check_val({tag, "_rs"},   ram_count_reset, 0);
  endtask

  task automatic inc_entry(input int a, input int n);
    repeat (n) begin
      tb_adr = 6'(a);
      inc    = 1'b1;
      @(negedge clk);
    end
    inc = 1'b0;
  endtask

  task automatic preload_mod16();
    wipe = 1'b1;
    @(negedge clk);
    wipe = 1'b0;
    for (int k = 0; k < 64; k++) inc_entry(k, k % 16);
  endtask

  // Runs one scan from the current falling edge. abort_at >= 0 aborts in SEND of that
  // address; restart_at > 0 pulses start at that cycle index of the running scan.
  task automatic do_scan(input bit clr, input bit skip, input bit rnd_ready,
                         input int abort_at, input int restart_at);
    int idx;
    bit prev_stall, prev_hs;
    logic [5:0] pv_adr;
    logic [3:0] pv_dat;
    beat_adr.delete(); beat_dat.delete(); beat_last.delete();
    got_done = 0; done_edge = -1;
    prev_stall = 0; prev_hs = 0; pv_adr = '0; pv_dat = '0;
    clear_after_read = clr;
    skip_zero        = skip;
    out_ready        = 1'b1;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx   = 1;
    while (1) begin
      if (idx == 1) begin
        check_val("read_strobe", ram_count_read, 1);
        check_val("read_adr0", ram_adress, 0);
        check_val("busy_read", busy, 1);
      end
      if (idx == 2 && !skip) check_val("vld_capt", out_valid, 0);
      if (idx == 3 && !skip) check_val("vld_send", out_valid, 1);
      if (ram_count_read && ram_count_reset) check_val("strobe_excl", 1, 0);
      if (prev_stall) begin
        check_val("stall_vld", out_valid, 1);
        check_val("stall_adr", out_adress, pv_adr);
        check_val("stall_dat", out_data, pv_dat);
      end
      if (prev_hs) check_val("vld_after_hs", out_valid, 0);
      if (done) begin
        got_done  = 1;
        done_edge = idx - 1;
        check_val("busy_in_fin", busy, 0);
        break;
      end
      if (idx > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL scan_timeout: no done after %0d cycles", idx);
        break;
      end
      start     = (idx == restart_at);
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && out_valid && out_adress == 6'(abort_at)) begin
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outs("abort");
        repeat (5) begin
          @(negedge clk);
          if (done || ram_count_read || ram_count_reset) check_val("abort_quiet", 1, 0);
        end
        break;
      end
      prev_stall = out_valid && !out_ready;
      prev_hs    = out_valid && out_ready;
      pv_adr     = out_adress;
      pv_dat     = out_data;
      if (out_valid && out_ready) begin
        beat_adr.push_back(int'(out_adress));
        beat_dat.push_back(int'(out_data));
        beat_last.push_back(int'(out_last));
      end
      @(negedge clk);
      idx++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  // Checks a full 64-beat sequence; entries below zero_below are expected to read 0.
  task automatic check_full_beats(input string tag, input bit all_zero, input int zero_below);
    int bad_adr, bad_dat, bad_last;
    bad_adr = 0; bad_dat = 0; bad_last = 0;
    check_val({tag, "_nbeats"}, beat_adr.size(), 64);
    for (int k = 0; k < 64 && k < beat_adr.size(); k++) begin
      if (beat_adr[k] != k) bad_adr++;
      if (beat_dat[k] != ((all_zero || k < zero_below) ? 0 : k % 16)) bad_dat++;
      if (beat_last[k] != ((k == 63) ? 1 : 0)) bad_last++;
    end
    check_val({tag, "_adr_errs"}, bad_adr, 0);
    check_val({tag, "_dat_errs"}, bad_dat, 0);
    check_val({tag, "_last_errs"}, bad_last, 0);
  endtask

  task automatic check_mem(input string tag, input int zero_below, input bit all_zero);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (int'(mem[k]) != ((all_zero || k < zero_below) ? 0 : k % 16)) bad++;
    check_val({tag, "_mem_errs"}, bad, 0);
  endtask

  initial begin
    gen_reset_n = 1'b0;
    start = 0; abort = 0; clear_after_read = 0; skip_zero = 0;
    out_ready = 0; inc = 0; wipe = 0; tb_adr = '0;
    #1;
    check_idle_outs("rst");
    check_val("rst_adr", ram_adress, 0);
    check_val("rst_oadr", out_adress, 0);
    check_val("rst_odat", out_data, 0);
    check_val("rst_last", out_last, 0);
    @(negedge clk);
    @(negedge clk);
    gen_reset_n = 1'b1;
    @(negedge clk);
    preload_mod16();

    // Plain scan
    do_scan(0, 0, 0, -1, -1);
    check_full_beats("plain", 0, 0);
    check_val("plain_done", got_done, 1);
    check_val("plain_cycles", done_edge, 192);
    check_mem("plain", 0, 0);

    // Clear-after-read scan, then a scan that must see only zeros
    do_scan(1, 0, 0, -1, -1);
    check_full_beats("clr", 0, 0);
    check_val("clr_cycles", done_edge, 256);
    check_mem("clr", 0, 1);
    do_scan(0, 0, 0, -1, -1);
    check_full_beats("zero", 1, 0);
    check_val("zero_cycles", done_edge, 192);

    // Skip-zero with two live entries: 62 skipped entries at 2 cycles, 2 sent at 3
    inc_entry(5, 3);
    inc_entry(63, 7);
    do_scan(0, 1, 0, -1, -1);
    check_val("skip_nbeats", beat_adr.size(), 2);
    if (beat_adr.size() == 2) begin
      check_val("skip_b0_adr", beat_adr[0], 5);
      check_val("skip_b0_dat", beat_dat[0], 3);
      check_val("skip_b0_last", beat_last[0], 0);
      check_val("skip_b1_adr", beat_adr[1], 63);
      check_val("skip_b1_dat", beat_dat[1], 7);
      check_val("skip_b1_last", beat_last[1], 1);
    end
    check_val("skip_done", got_done, 1);
    check_val("skip_cycles", done_edge, 130);

    // Random backpressure with a start pulse mid-scan that must be ignored
    preload_mod16();
    do_scan(0, 0, 1, -1, 40);
    check_full_beats("stall", 0, 0);
    check_val("stall_done", got_done, 1);

    // Abort during SEND of address 10 in clear mode
    do_scan(1, 0, 0, 10, -1);
    check_val("abort_done", got_done, 0);
    check_val("abort_nbeats", beat_adr.size(), 10);
    check_mem("abort", 10, 0);

    // Asynchronous reset mid-scan, then a fresh scan from address 0
    clear_after_read = 1'b0;
    skip_zero        = 1'b0;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    gen_reset_n = 1'b0;
    #1;
    check_idle_outs("arst");
    check_val("arst_adr", ram_adress, 0);
    check_val("arst_oadr", out_adress, 0);
    check_val("arst_odat", out_data, 0);
    check_val("arst_last", out_last, 0);
    @(negedge clk);
    gen_reset_n = 1'b1;
    @(negedge clk);
    check_mem("arst", 10, 0);
    do_scan(0, 0, 0, -1, -1);
    check_full_beats("after_rst", 0, 10);
    check_val("after_rst_cycles", done_edge, 192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_scan_reader.md
# counter_scan_reader

Sequential readout engine for the counter RAM (`ContadoresRAM`-style port set: address, count_read, count_reset, registered count_out). On `start` it walks every counter address from 0 to 2**bitsDirect-1 and reads each value. It presents each value as an (address, count) beat on a valid/ready output stream. Options: clear each counter after it is delivered, and skip zero-valued entries. It is the reader side of the histogram/event-counter path; the increment path is the writer.

## Interface
Parameters:
- `bitsDirect`, 6, counter RAM address width; the scan covers 2**bitsDirect entries.
- `sizeCounter`, 4, counter width; equals the RAM `count_out` width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `gen_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `abort`  in  1  synchronous; terminates the scan at the next edge.
- `clear_after_read`  in  1  scan mode; latched at start.
- `skip_zero`  in  1  scan mode; latched at start.
- `busy`  out  1  scan in progress; the system gates the increment path with it.
- `done`  out  1  one-cycle pulse when a full scan completes.
- `ram_adress`  out  bitsDirect  RAM address.
- `ram_count_read`  out  1  RAM read strobe.
- `ram_count_reset`  out  1  RAM per-entry clear strobe.
- `ram_count_out`  in  sizeCounter  RAM registered read data.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_adress`  out  bitsDirect  address of the beat.
- `out_data`  out  sizeCounter  counter value of the beat.
- `out_last`  out  1  the beat is for address 2**bitsDirect-1.

## Operation
- FSM states:
  - IDLE
  - READ: `ram_count_read`=1 at `ram_adress`=addr.
  - CAPT: `ram_count_out` is now valid for addr.
  - SEND: `out_valid`=1, waiting for handshake.
  - CLEAR: `ram_count_reset`=1 at addr.
  - FIN: `done`=1.
- Transitions:
  - IDLE: `start`&!`abort` -> READ with addr=0; mode bits are latched on this edge.
  - READ -> CAPT.
  - CAPT with `skip_zero` and `ram_count_out`==0 -> advance. Otherwise CAPT -> SEND, registering addr and `ram_count_out` into `out_adress` and `out_data`.
  - SEND with `out_valid`&`out_ready` -> CLEAR if `clear_after_read`, else advance.
  - CLEAR -> advance.
  - advance: addr==2**bitsDirect-1 -> FIN; otherwise addr+1 -> READ.
  - FIN -> IDLE.
- `abort` takes any state except IDLE to IDLE on the next edge. On abort: no `done`, `out_valid` drops, and no further RAM strobes.
- `start` while not in IDLE is ignored. `abort` wins over a simultaneous `start`.
- `ram_count_read` and `ram_count_reset` are never high in the same cycle. Both RAM strobes are 0 in IDLE, SEND and FIN.
- `ram_adress` always equals addr.
- A skipped zero entry is not cleared, because it is already 0.
- `out_last`: qualified by `out_valid`. It is set only for the final address. If that entry is skipped, no beat carries `out_last`; `done` still pulses.
- addr is exactly bitsDirect bits wide. It never wraps: FIN is taken at the maximum address.
- An increment landing on addr between READ and CLEAR is lost. Gating the increment path with `busy` is mandatory at system level.

## Timing
- Reset values: state IDLE, addr 0, all outputs 0.
- Cycle E0 is the edge that samples `start`. READ is active in the cycle after E0. CAPT follows E1. `out_valid` goes high after E2.
- `out_valid` and `out_data` stay stable until the handshake edge. `out_valid` is low in the cycle after the handshake.
- Per-entry cost with `out_ready` held 1:
  - 3 cycles without clear.
  - 4 cycles with clear.
  - 2 cycles for a skipped entry.
- Full scan with 64 entries, no clear, no skip, ready=1: FIN follows 192 cycles after E0.
- `busy` is high from the cycle after E0 through the last CLEAR/SEND/CAPT cycle. It is low in FIN, where `done`=1.
- Asynchronous reset mid-scan returns every output to 0 immediately. The RAM contents are not touched.

## Structure
- `counter_scan_pkg` holds:
  - the state enum `scan_state_t` {IDLE, READ, CAPT, SEND, CLEAR, FIN};
  - a `SCAN_LAST` constant function of bitsDirect.
- Single module; no sub-module. The bench instantiates it together with the counter RAM as the DUT pair, with the RAM reset tied to !`gen_reset_n`.

## Test plan
- Preload RAM via increments so entry k holds k mod 16. Scan with no clear, no skip, `out_ready`=1 -> 64 beats, address k with data k mod 16; `out_last` only on address 63; `done` pulses 192 cycles after start; RAM unchanged.
- Same preload with `clear_after_read`=1 -> same 64 beats, `done` 256 cycles after start; a second scan returns all zeros.
- `skip_zero`=1 with only entries 5 and 63 nonzero (3 and 7) -> exactly 2 beats, (5,3) and (63,7); `out_last` on the second beat.
- `out_ready` toggled 1-0-0-1 randomly -> each beat is held stable while stalled; no beat is duplicated or dropped; beat order is 0..63.
- `abort` asserted during SEND of address 10, in clear mode -> `out_valid` low next cycle, no `done`, entries 0-9 cleared and 10-63 intact. `start` during a scan is ignored.
- `gen_reset_n` low mid-scan -> all outputs 0 immediately; a later `start` scans from address 0.
